// File: rtl/change_dispenser_fsm.sv
// Coin-return back end: pays a change amount out as greedy 25/10/5 eject
// pulses, tracks the inventory of each coin tube and flags a shortfall when
// exact change cannot be paid from the coins on hand.
module change_dispenser_fsm #(
  parameter int AMT_W     = 8,
  parameter int TUBE_W    = 6,
  parameter int Q_INIT    = 10,
  parameter int D_INIT    = 10,
  parameter int N_INIT    = 10,
  parameter int PULSE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              change_valid,
  input  logic [AMT_W-1:0]  change_amt,
  input  logic              refill,
  output logic              busy,
  output logic              eject25,
  output logic              eject10,
  output logic              eject5,
  output logic              done,
  output logic              short,
  output logic [AMT_W-1:0]  remaining,
  output logic [TUBE_W-1:0] q_cnt,
  output logic [TUBE_W-1:0] d_cnt,
  output logic [TUBE_W-1:0] n_cnt
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);

  localparam logic [AMT_W-1:0] C25 = AMT_W'(25);
  localparam logic [AMT_W-1:0] C10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] C5  = AMT_W'(5);

  localparam logic [TUBE_W-1:0] Q_RST = TUBE_W'(Q_INIT);
  localparam logic [TUBE_W-1:0] D_RST = TUBE_W'(D_INIT);
  localparam logic [TUBE_W-1:0] N_RST = TUBE_W'(N_INIT);

  state_t            state, state_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_nx;
  logic [AMT_W-1:0]  rem_nx;
  logic [TUBE_W-1:0] q_nx, d_nx, n_nx;
  logic              e25_nx, e10_nx, e5_nx;
  logic              busy_nx, done_nx, short_nx;

  // Next-state, datapath and next-output logic; all outputs are registered
  // from these so every output is a clean Moore flop.
  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    rem_nx   = remaining;
    q_nx     = q_cnt;
    d_nx     = d_cnt;
    n_nx     = n_cnt;
    e25_nx   = 1'b0;
    e10_nx   = 1'b0;
    e5_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (change_valid) begin
          rem_nx   = change_amt;
          state_nx = SELECT;
        end else if (refill) begin
          q_nx = Q_RST;
          d_nx = D_RST;
          n_nx = N_RST;
        end
      end
      SELECT: begin
        if (remaining >= C25 && q_cnt != '0) begin
          e25_nx   = 1'b1;
          rem_nx   = remaining - C25;
          q_nx     = q_cnt - 1'b1;
          state_nx = PULSE;
        end else if (remaining >= C10 && d_cnt != '0) begin
          e10_nx   = 1'b1;
          rem_nx   = remaining - C10;
          d_nx     = d_cnt - 1'b1;
          state_nx = PULSE;
        end else if (remaining >= C5 && n_cnt != '0) begin
          e5_nx    = 1'b1;
          rem_nx   = remaining - C5;
          n_nx     = n_cnt - 1'b1;
          state_nx = PULSE;
        end else begin
          state_nx = DONE;
        end
      end
      PULSE: begin
        gap_nx = '0;
        if (PULSE_GAP > 0) state_nx = GAP;
        else               state_nx = SELECT;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = SELECT;
        else                     gap_nx   = gap_cnt + 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
    short_nx = (state_nx == DONE) && (rem_nx != '0);
  end

  // State, datapath and output registers; reset aborts any payout and
  // reloads the tubes without reporting what was already paid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      remaining <= '0;
      q_cnt     <= Q_RST;
      d_cnt     <= D_RST;
      n_cnt     <= N_RST;
      eject25   <= 1'b0;
      eject10   <= 1'b0;
      eject5    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
    end else begin
      state     <= state_nx;
      gap_cnt   <= gap_nx;
      remaining <= rem_nx;
      q_cnt     <= q_nx;
      d_cnt     <= d_nx;
      n_cnt     <= n_nx;
      eject25   <= e25_nx;
      eject10   <= e10_nx;
      eject5    <= e5_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      short     <= short_nx;
    end
  end

endmodule

// File: doc/change_dispenser_fsm.md
Name: change_dispenser_fsm

Overview:
Coin-return back end for the vending machine FSM. It consumes the `change` amount the vending machine reports after a sale and pays it out as discrete coin-eject pulses (25/10/5 units) to the coin-tube solenoids. It tracks the coin inventory of each tube and reports a shortfall when exact change cannot be paid.

Parameters:
AMT_W, 8, width of change amount and remaining-amount datapath
TUBE_W, 6, width of each coin-tube inventory counter
Q_INIT, 10, quarter (25) tube count after reset/refill; must be <= 2^TUBE_W-1
D_INIT, 10, dime (10) tube count after reset/refill
N_INIT, 10, nickel (5) tube count after reset/refill
PULSE_GAP, 1, idle cycles after each eject pulse (0 allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
change_valid  input  1  one-cycle strobe: change_amt is valid
change_amt  input  AMT_W  amount to return, unsigned
refill  input  1  restore all tubes to INIT values (honoured in IDLE only)
busy  output  1  high from acceptance until the DONE cycle inclusive
eject25  output  1  one-cycle quarter eject pulse
eject10  output  1  one-cycle dime eject pulse
eject5  output  1  one-cycle nickel eject pulse
done  output  1  one-cycle completion pulse
short  output  1  valid with done: 1 = amount not fully paid
remaining  output  AMT_W  unpaid amount; updated each pulse, final value held after done
q_cnt  output  TUBE_W  quarters in tube
d_cnt  output  TUBE_W  dimes in tube
n_cnt  output  TUBE_W  nickels in tube

Behaviour:
- Reset values:
  - State IDLE.
  - busy, eject25/10/5, done, short = 0.
  - remaining = 0.
  - q_cnt/d_cnt/n_cnt = Q_INIT/D_INIT/N_INIT.
- Outputs are registered Moore outputs.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - change_valid=1 at edge E0: rem <= change_amt, go to SELECT, busy=1 from E0.
  - Else refill=1: tubes <= INIT values.
  - change_valid has priority over refill in the same cycle; that refill is dropped.
- SELECT (one cycle): greedy choice, in order 25, 10, 5, of the first coin c with rem >= c and tube count > 0.
  - If a coin is found: at the next edge go to PULSE, assert its eject output for exactly one cycle, rem <= rem - c, tube count decrements at the same edge.
  - If none is found: go to DONE.
  - No backtracking. Example: rem=30 with quarters available and no nickels ejects 25, then ends short with remaining=5.
- PULSE: lasts one cycle, then goes to GAP if PULSE_GAP>0, else directly to SELECT.
- GAP: counts PULSE_GAP cycles, then goes to SELECT.
- Coin period: 2+PULSE_GAP cycles.
- DONE (one cycle):
  - done=1; short=(rem!=0); remaining=rem.
  - busy remains 1 this cycle; next state IDLE.
- Timing with PULSE_GAP=1 and change_amt=15 accepted at E0:
  - eject10 high in the cycle after E1.
  - eject5 high in the cycle after E4.
  - done high in the cycle after E7.
- Amount zero or below 5: no pulses; done is high in the cycle after E1. short = (amt!=0), remaining = amt.
- Amounts not divisible by 5: pay as far as possible, then short=1 with remaining = amt mod 5 (given sufficient tubes).
- At most one eject output is high in any cycle.
- Tube counters never underflow, because selection requires count > 0.
- Inputs while busy:
  - change_valid is ignored and the transaction is lost; the upstream must wait for busy=0.
  - refill is ignored.
- rst mid-operation:
  - Aborts immediately to IDLE and clears all pulses at the next edge.
  - Tubes reload to INIT values; partial payout is not reported.

Test Plan:
1. Assert rst 2 cycles -> busy=eject*=done=short=0, remaining=0, q/d/n_cnt=10/10/10.
2. change_amt=15, PULSE_GAP=1 -> eject10 then eject5, 3 cycles apart; done 3 cycles after eject5 with short=0; remaining=0; d_cnt=9; n_cnt=9.
3. change_amt=40 -> pulse order 25, 10, 5; done with short=0; counts 9/9/9. Repeat change_amt=25 -> single eject25, q_cnt=8.
4. Q_INIT=0, N_INIT=1, change_amt=30 -> eject10 x3, short=0. Then D_INIT=0, Q_INIT=1, N_INIT=0, change_amt=30 -> eject25 only, done with short=1, remaining=5.
5. Amount corners:
   - change_amt=0 -> no pulses, done in the cycle after E1, short=0.
   - change_amt=3 -> same timing, short=1, remaining=3.
   - change_amt=17 -> eject10 and eject5, short=1, remaining=2.
6. Robustness:
   - change_valid pulsed while busy -> ignored; only the first payout occurs.
   - refill while busy -> counts unchanged.
   - rst asserted between two pulses of change_amt=40 -> no further ejects, counts back to 10/10/10, done never asserted.
